// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter8_onehot_dec3.sv
// Combinational 3-to-8 one-hot decoder: out_o = 1 << in_i.
module onehot_dec3
  import rr_arbiter8_pkg::*;
(
  input  logic [IDX_W-1:0]   in_i,
  output logic [NUM_REQ-1:0] out_o
);

  always_comb begin
    out_o = NUM_REQ'(1) << in_i;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with bounded hold time and a
// mandatory one-cycle bubble between grants.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               expire
);

  localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic             expire_q, expire_d;
  logic [NUM_REQ-1:0] dec;

  // Scan from farthest to nearest offset so the nearest requester at or
  // after the pointer is the last one written.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] idx;
    rr_pick = p;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = p + IDX_W'(NUM_REQ - 1 - k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    expire_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = rr_pick(req, ptr_q);
          hold_d  = '0;
        end
      end
      GRANT: begin
        // A voluntary drop wins over expiry when both land on the last cycle.
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = idx_q + 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d  = IDLE;
          ptr_d    = idx_q + 1'b1;
          expire_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      expire_q <= expire_d;
    end
  end

  onehot_dec3 u_dec (
    .in_i  (idx_q),
    .out_o (dec)
  );

  assign gnt_valid = (state_q == GRANT);
  assign gnt       = gnt_valid ? dec : '0;
  assign gnt_idx   = idx_q;
  assign expire    = expire_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with a cycle-level behavioural model.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       expire;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .expire    (expire)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a grant is a winner plus a count of cycles served.
  int m_busy, m_win, m_cyc, m_ptr, m_exp;

  function automatic int first_from(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_win <= 0; m_cyc <= 0; m_ptr <= 0; m_exp <= 0;
    end else if (m_busy == 0) begin
      m_exp <= 0;
      if (req != 8'h00) begin
        m_win  <= first_from(req, m_ptr);
        m_busy <= 1;
        m_cyc  <= 1;
      end
    end else begin
      m_exp <= 0;
      if (!req[m_win]) begin
        m_busy <= 0;
        m_ptr  <= (m_win + 1) % 8;
      end else if (m_cyc == MH) begin
        m_busy <= 0;
        m_ptr  <= (m_win + 1) % 8;
        m_exp  <= 1;
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] one;
    one = 8'h01;
    check("model_gnt",    32'(gnt),       m_busy != 0 ? 32'(one << m_win) : 32'h0);
    check("model_idx",    32'(gnt_idx),   32'(m_win));
    check("model_valid",  32'(gnt_valid), 32'(m_busy != 0));
    check("model_expire", 32'(expire),    32'(m_exp));
  end

  logic [7:0] a_gnt [11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                             8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};
  logic       a_exp [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   starts[$];
    int   wins[$];
    logic prev;

    rst_n = 1'b0;
    req   = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_valid", 32'(gnt_valid), 32'h0);
      check("rst_idx", 32'(gnt_idx), 32'h0);
      check("rst_expire", 32'(expire), 32'h0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_expire", 32'(expire), 32'h0);
    end

    // Two requesters at the ends of the ring: hold, expire, wrap.
    req = 8'h81;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check("h81_gnt", 32'(gnt), 32'(a_gnt[k]));
      check("h81_expire", 32'(expire), 32'(a_exp[k]));
    end

    // Full contention: rotation order and period.
    do_reset();
    req  = 8'hFF;
    prev = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (gnt_valid && !prev) begin
        starts.push_back(c);
        wins.push_back(int'(gnt_idx));
      end
      prev = gnt_valid;
    end
    check("ff_nstarts_ge9", 32'(starts.size() >= 9), 32'h1);
    if (starts.size() >= 9) begin
      check("ff_first_start", 32'(starts[0]), 32'd0);
      for (int k = 0; k < 9; k++) check("ff_winner", 32'(wins[k]), 32'(k % 8));
      check("ff_period", 32'(starts[8] - starts[0]), 32'd40);
    end

    // Early voluntary release after two cycles, then pointer has moved to 3.
    do_reset();
    req = 8'h04;
    @(negedge clk); check("drop2_gnt_c1", 32'(gnt), 32'h04);
    @(negedge clk); check("drop2_gnt_c2", 32'(gnt), 32'h04);
    req = 8'h00;
    @(negedge clk);
    check("drop2_gnt_after", 32'(gnt), 32'h00);
    check("drop2_expire", 32'(expire), 32'h0);
    req = 8'h0C;
    @(negedge clk);
    check("drop2_next_idx", 32'(gnt_idx), 32'd3);
    check("drop2_next_gnt", 32'(gnt), 32'h08);

    // Drop coinciding with the last allowed grant cycle: no expire.
    do_reset();
    req = 8'h04;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("coinc_gnt", 32'(gnt), 32'h04);
    end
    req = 8'h00;
    @(negedge clk);
    check("coinc_gnt_after", 32'(gnt), 32'h00);
    check("coinc_expire", 32'(expire), 32'h0);

    // Move the pointer past 4, regrant 4 via wrap, then reset mid-grant.
    req = 8'h10;
    @(negedge clk); check("pre_rst_gnt", 32'(gnt), 32'h10);
    req = 8'h00;
    @(negedge clk); check("pre_rst_release", 32'(gnt), 32'h00);
    req = 8'h10;
    @(negedge clk); check("pre_rst_wrap_gnt", 32'(gnt), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h00);
    check("async_rst_valid", 32'(gnt_valid), 32'h0);
    check("async_rst_expire", 32'(expire), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h30;
    @(negedge clk);
    check("post_rst_idx", 32'(gnt_idx), 32'd4);
    check("post_rst_gnt", 32'(gnt), 32'h10);

    req = 8'h00;
    repeat (6) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
